// File: rtl/core_lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Holds the FSM state enum, opcode and funct3 encodings.
package core_lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } lsu_state_e;

    localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    function automatic logic f3_legal(
        input logic       is_store,
        input logic [2:0] f3
    );
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!is_store) begin
            ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
        end
        return ok;
    endfunction

endpackage

// File: rtl/core_lsu_align.sv
// Byte-lane steering for the LSU (combinational).
// Ports: st_size/st_off/st_wdata -> st_be, st_wdata_o, st_mis;
//        ld_f3/ld_off/ld_rdata -> ld_data (extended).
module lsu_align
    import core_lsu_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata_o,
    output logic        st_mis,
    input  logic [2:0]  ld_f3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // size encoding is funct3[1:0]: 0 byte, 1 half, 2 word
    always_comb begin
        st_be      = 4'b0000;
        st_wdata_o = st_wdata;
        st_mis     = 1'b0;
        unique case (st_size)
            2'd0: begin
                st_be      = 4'b0001 << st_off;
                st_wdata_o = {4{st_wdata[7:0]}};
            end
            2'd1: begin
                st_be      = st_off[1] ? 4'b1100 : 4'b0011;
                st_wdata_o = {2{st_wdata[15:0]}};
                st_mis     = st_off[0];
            end
            default: begin
                st_be  = 4'b1111;
                st_mis = (st_off != 2'd0);
            end
        endcase
    end

    always_comb begin
        unique case (ld_off)
            2'd0:    ld_byte = ld_rdata[7:0];
            2'd1:    ld_byte = ld_rdata[15:8];
            2'd2:    ld_byte = ld_rdata[23:16];
            default: ld_byte = ld_rdata[31:24];
        endcase
        ld_half = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];
        case (ld_f3)
            F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   ld_data = {24'd0, ld_byte};
            F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            F3_HU:   ld_data = {16'd0, ld_half};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/core_lsu.sv
// Load/store unit between EX and WB, driving a req/gnt/rvalid memory port.
// Ports: EX op in (valid/opcode/funct3/rd/addr/wdata), ready_o stall,
//        misaligned_o pulse, dmem_* request/response, wb_* load result.
module core_lsu
    import core_lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    input  logic [6:0]      opcode_i,
    input  logic [2:0]      funct3_i,
    input  logic [4:0]      rd_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic            ready_o,
    output logic            misaligned_o,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [3:0]      dmem_be_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    input  logic            dmem_gnt_i,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic            wb_valid_o,
    output logic [4:0]      wb_rd_o,
    output logic [XLEN-1:0] wb_data_o
);

    lsu_state_e state_q, state_d;

    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        we_q, we_d;
    logic [4:0]  rd_q, rd_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic        mis_q, mis_d;
    logic        wbv_q, wbv_d;
    logic [4:0]  wbrd_q, wbrd_d;
    logic [31:0] wbdat_q, wbdat_d;

    logic        is_ld, is_st, legal, go, accept;
    logic [3:0]  al_be;
    logic [31:0] al_wdata, al_ldata;
    logic        al_mis;

    lsu_align u_align (
        .st_size    (funct3_i[1:0]),
        .st_off     (addr_i[1:0]),
        .st_wdata   (wdata_i),
        .st_be      (al_be),
        .st_wdata_o (al_wdata),
        .st_mis     (al_mis),
        .ld_f3      (f3_q),
        .ld_off     (off_q),
        .ld_rdata   (dmem_rdata_i),
        .ld_data    (al_ldata)
    );

    assign is_ld  = (opcode_i == OPCODE_LOAD);
    assign is_st  = (opcode_i == OPCODE_STORE);
    assign legal  = (is_ld || is_st) && f3_legal(is_st, funct3_i);
    assign go     = (state_q == IDLE) && valid_i && legal;
    assign accept = go && !al_mis;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = REQ;
            REQ:     if (dmem_gnt_i) state_d = we_q ? IDLE : WAIT;
            WAIT:    if (dmem_rvalid_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        we_d    = we_q;
        rd_d    = rd_q;
        f3_d    = f3_q;
        off_d   = off_q;
        if (accept) begin
            addr_d  = {addr_i[31:2], 2'b00};
            wdata_d = al_wdata;
            be_d    = al_be;
            we_d    = is_st;
            rd_d    = rd_i;
            f3_d    = funct3_i;
            off_d   = addr_i[1:0];
        end
        mis_d   = go && al_mis;
        wbv_d   = (state_q == WAIT) && dmem_rvalid_i;
        wbrd_d  = wbv_d ? rd_q : wbrd_q;
        wbdat_d = wbv_d ? al_ldata : wbdat_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            rd_q    <= '0;
            f3_q    <= '0;
            off_q   <= '0;
            mis_q   <= 1'b0;
            wbv_q   <= 1'b0;
            wbrd_q  <= '0;
            wbdat_q <= '0;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            we_q    <= we_d;
            rd_q    <= rd_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            mis_q   <= mis_d;
            wbv_q   <= wbv_d;
            wbrd_q  <= wbrd_d;
            wbdat_q <= wbdat_d;
        end
    end

    always_comb begin
        ready_o      = (state_q == IDLE);
        dmem_req_o   = (state_q == REQ);
        dmem_we_o    = we_q;
        dmem_be_o    = be_q;
        dmem_addr_o  = addr_q;
        dmem_wdata_o = wdata_q;
        misaligned_o = mis_q;
        wb_valid_o   = wbv_q;
        wb_rd_o      = wbrd_q;
        wb_data_o    = wbdat_q;
    end

endmodule

// File: tb/tb_core_lsu.sv
// Scoreboard bench for core_lsu: memory requests and load results
// are predicted on issue and compared when the DUT produces them.
module tb_core_lsu;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } req_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic [6:0]  opcode_i;
    logic [2:0]  funct3_i;
    logic [4:0]  rd_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        ready_o;
    logic        misaligned_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        wb_valid_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;

    int n_chk = 0;
    int n_fail = 0;

    req_t req_q[$];
    wb_t  wb_q[$];

    always #5 clk = ~clk;

    core_lsu #(.XLEN(32)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .valid_i       (valid_i),
        .opcode_i      (opcode_i),
        .funct3_i      (funct3_i),
        .rd_i          (rd_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .ready_o       (ready_o),
        .misaligned_o  (misaligned_o),
        .dmem_req_o    (dmem_req_o),
        .dmem_we_o     (dmem_we_o),
        .dmem_be_o     (dmem_be_o),
        .dmem_addr_o   (dmem_addr_o),
        .dmem_wdata_o  (dmem_wdata_o),
        .dmem_gnt_i    (dmem_gnt_i),
        .dmem_rvalid_i (dmem_rvalid_i),
        .dmem_rdata_i  (dmem_rdata_i),
        .wb_valid_o    (wb_valid_o),
        .wb_rd_o       (wb_rd_o),
        .wb_data_o     (wb_data_o)
    );

    task automatic chk(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] m_be(
        input logic [2:0] f3,
        input logic [1:0] o
    );
        case (f3)
            3'd0, 3'd4: return (o == 2'd0) ? 4'b0001 :
                               (o == 2'd1) ? 4'b0010 :
                               (o == 2'd2) ? 4'b0100 : 4'b1000;
            3'd1, 3'd5: return (o == 2'd2) ? 4'b1100 : 4'b0011;
            default:    return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] m_wd(
        input logic [2:0]  f3,
        input logic [31:0] d
    );
        case (f3)
            3'd0:    return {d[7:0], d[7:0], d[7:0], d[7:0]};
            3'd1:    return {d[15:0], d[15:0]};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] m_ld(
        input logic [2:0]  f3,
        input logic [1:0]  o,
        input logic [31:0] w
    );
        logic [31:0] s;
        s = w >> (8 * o);
        case (f3)
            3'd0:    return {{24{s[7]}}, s[7:0]};
            3'd4:    return {24'h0, s[7:0]};
            3'd1:    return {{16{s[15]}}, s[15:0]};
            3'd5:    return {16'h0, s[15:0]};
            default: return w;
        endcase
    endfunction

    // scoreboard checks at the falling edge, away from the clock edge
    always @(negedge clk) begin
        if (!rst_i && dmem_req_o && dmem_gnt_i) begin
            if (req_q.size() == 0) begin
                chk("req_unexpected", 32'd1, 32'd0);
            end else begin
                req_t r;
                r = req_q.pop_front();
                chk("dmem_addr", dmem_addr_o, r.addr);
                chk("dmem_be", {28'd0, dmem_be_o}, {28'd0, r.be});
                chk("dmem_we", {31'd0, dmem_we_o}, {31'd0, r.we});
                chk("dmem_wdata", dmem_wdata_o, r.wdata);
            end
        end
        if (wb_valid_o) begin
            if (wb_q.size() == 0) begin
                chk("wb_unexpected", 32'd1, 32'd0);
            end else begin
                wb_t w;
                w = wb_q.pop_front();
                chk("wb_rd", {27'd0, wb_rd_o}, {27'd0, w.rd});
                chk("wb_data", wb_data_o, w.data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(
        input logic [6:0]  op,
        input logic [2:0]  f3,
        input logic [4:0]  rd,
        input logic [31:0] a,
        input logic [31:0] d
    );
        valid_i  = 1'b1;
        opcode_i = op;
        funct3_i = f3;
        rd_i     = rd;
        addr_i   = a;
        wdata_i  = d;
    endtask

    // full transaction: accept, gnt after gdly cycles, rvalid next cycle
    task automatic do_op(
        input logic [6:0]  op,
        input logic [2:0]  f3,
        input logic [4:0]  rd,
        input logic [31:0] a,
        input logic [31:0] d,
        input int          gdly,
        input logic [31:0] rdata
    );
        req_t r;
        wb_t  w;
        logic st;
        st = (op == ST);
        chk("ready_before", {31'd0, ready_o}, 32'd1);
        r.addr  = {a[31:2], 2'b00};
        r.be    = m_be(f3, a[1:0]);
        r.we    = st;
        r.wdata = st ? m_wd(f3, d) : 32'h0;
        if (!st) r.wdata = 32'h0;
        req_q.push_back(r);
        drive(op, f3, rd, a, d);
        step();
        valid_i = 1'b0;
        for (int i = 0; i < gdly; i++) begin
            chk("req_held", {31'd0, dmem_req_o}, 32'd1);
            chk("ready_busy", {31'd0, ready_o}, 32'd0);
            chk("addr_held", dmem_addr_o, r.addr);
            chk("be_held", {28'd0, dmem_be_o}, {28'd0, r.be});
            // an extra op during REQ must be ignored
            drive(ST, 3'd2, 5'd0, 32'h0000_0F00, 32'h1);
            step();
            valid_i = 1'b0;
        end
        chk("req_on", {31'd0, dmem_req_o}, 32'd1);
        dmem_gnt_i = 1'b1;
        step();
        dmem_gnt_i = 1'b0;
        chk("req_drop", {31'd0, dmem_req_o}, 32'd0);
        if (st) begin
            chk("st_ready", {31'd0, ready_o}, 32'd1);
            step();
            chk("st_no_wb", {31'd0, wb_valid_o}, 32'd0);
        end else begin
            chk("ld_wait", {31'd0, ready_o}, 32'd0);
            w.rd   = rd;
            w.data = m_ld(f3, a[1:0], rdata);
            wb_q.push_back(w);
            dmem_rvalid_i = 1'b1;
            dmem_rdata_i  = rdata;
            step();
            dmem_rvalid_i = 1'b0;
            dmem_rdata_i  = 32'hBAD0_BAD0;
            chk("ld_wbv", {31'd0, wb_valid_o}, 32'd1);
            chk("ld_ready", {31'd0, ready_o}, 32'd1);
            step();
            chk("wbv_pulse", {31'd0, wb_valid_o}, 32'd0);
            chk("wb_hold", wb_data_o, w.data);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i = 1'b1;
        valid_i = 1'b0;
        opcode_i = '0;
        funct3_i = '0;
        rd_i = '0;
        addr_i = '0;
        wdata_i = '0;
        dmem_gnt_i = 1'b0;
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i = '0;
        step();
        step();
        chk("rst_ready", {31'd0, ready_o}, 32'd1);
        chk("rst_req", {31'd0, dmem_req_o}, 32'd0);
        chk("rst_addr", dmem_addr_o, 32'd0);
        chk("rst_wb", {31'd0, wb_valid_o}, 32'd0);
        rst_i = 1'b0;
        step();

        do_op(ST, 3'd2, 5'd0, 32'h100, 32'hDEADBEEF, 0, 32'h0);
        do_op(ST, 3'd0, 5'd0, 32'h203, 32'h000000A5, 0, 32'h0);
        do_op(ST, 3'd1, 5'd0, 32'h402, 32'h1234CAFE, 1, 32'h0);
        do_op(LD, 3'd0, 5'd5, 32'h102, 32'h0, 0, 32'h12F43456);
        do_op(LD, 3'd4, 5'd5, 32'h102, 32'h0, 0, 32'h12F43456);
        do_op(LD, 3'd1, 5'd7, 32'h202, 32'h0, 0, 32'h8001_7FFF);
        do_op(LD, 3'd5, 5'd8, 32'h200, 32'h0, 0, 32'h1234_9ABC);
        do_op(LD, 3'd2, 5'd0, 32'h300, 32'h0, 3, 32'hA5A5_0F0F);

        // misaligned half load
        drive(LD, 3'd1, 5'd3, 32'h101, 32'h0);
        step();
        valid_i = 1'b0;
        chk("mis_pulse", {31'd0, misaligned_o}, 32'd1);
        chk("mis_noreq", {31'd0, dmem_req_o}, 32'd0);
        chk("mis_ready", {31'd0, ready_o}, 32'd1);
        step();
        chk("mis_end", {31'd0, misaligned_o}, 32'd0);
        chk("mis_noreq2", {31'd0, dmem_req_o}, 32'd0);

        // misaligned word store
        drive(ST, 3'd2, 5'd0, 32'h106, 32'h1);
        step();
        valid_i = 1'b0;
        chk("misw_pulse", {31'd0, misaligned_o}, 32'd1);
        chk("misw_noreq", {31'd0, dmem_req_o}, 32'd0);

        // illegal funct3 and non-memory opcode are ignored
        drive(LD, 3'd3, 5'd1, 32'h100, 32'h0);
        step();
        drive(7'b0110011, 3'd2, 5'd1, 32'h100, 32'h0);
        step();
        valid_i = 1'b0;
        chk("ill_ready", {31'd0, ready_o}, 32'd1);
        chk("ill_noreq", {31'd0, dmem_req_o}, 32'd0);
        chk("ill_nomis", {31'd0, misaligned_o}, 32'd0);

        // rvalid and gnt in IDLE are ignored
        dmem_rvalid_i = 1'b1;
        dmem_gnt_i = 1'b1;
        step();
        dmem_rvalid_i = 1'b0;
        dmem_gnt_i = 1'b0;
        step();
        chk("idle_rv", {31'd0, wb_valid_o}, 32'd0);
        chk("idle_ready", {31'd0, ready_o}, 32'd1);

        // reset during WAIT, then a late rvalid
        req_q.push_back('{addr: 32'h500, be: 4'b1111,
                          we: 1'b0, wdata: 32'h0});
        drive(LD, 3'd2, 5'd9, 32'h500, 32'h0);
        step();
        valid_i = 1'b0;
        dmem_gnt_i = 1'b1;
        step();
        dmem_gnt_i = 1'b0;
        chk("rw_wait", {31'd0, ready_o}, 32'd0);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i = 32'h7777_7777;
        step();
        dmem_rvalid_i = 1'b0;
        chk("rw_nowb", {31'd0, wb_valid_o}, 32'd0);
        chk("rw_ready", {31'd0, ready_o}, 32'd1);
        chk("rw_req", {31'd0, dmem_req_o}, 32'd0);
        chk("rw_addr", dmem_addr_o, 32'd0);
        chk("rw_be", {28'd0, dmem_be_o}, 32'd0);
        chk("rw_wbdata", wb_data_o, 32'd0);
        chk("rw_wbrd", {27'd0, wb_rd_o}, 32'd0);
        chk("rw_mis", {31'd0, misaligned_o}, 32'd0);
        step();

        chk("req_q_empty", req_q.size(), 32'd0);
        chk("wb_q_empty", wb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/core_lsu.md
Name: core_lsu

Overview:
- Load/store unit that consumes the EX-stage address (ALU result) and store data (forwarded rs2) and drives the data-memory request/grant/response handshake.
- Returns aligned, sign- or zero-extended load data to the WB path.
- Sits between EX and WB. While a memory operation is outstanding it deasserts ready_o, which the pipeline uses as a stall.

Parameters:
XLEN, 32, datapath and address width (only 32 supported)

Ports:
clk_i  in  1  clock, all state changes on rising edge
rst_i  in  1  synchronous active-high reset
valid_i  in  1  EX presents a memory op this cycle
opcode_i  in  7  EX opcode; only LOAD (0000011) and STORE (0100011) act
funct3_i  in  3  access size/sign
rd_i  in  5  load destination register
addr_i  in  XLEN  byte address from ALU
wdata_i  in  XLEN  store data (forwarded rs2)
ready_o  out  1  LSU idle and able to accept
misaligned_o  out  1  one-cycle pulse, misaligned access rejected
dmem_req_o  out  1  memory request
dmem_we_o  out  1  1 = store
dmem_be_o  out  4  byte enables
dmem_addr_o  out  XLEN  word-aligned address
dmem_wdata_o  out  XLEN  lane-shifted store data
dmem_gnt_i  in  1  memory accepted request
dmem_rvalid_i  in  1  load data valid
dmem_rdata_i  in  XLEN  load word
wb_valid_o  out  1  one-cycle pulse, load result valid
wb_rd_o  out  5  load destination
wb_data_o  out  XLEN  extended load data

Behaviour:
- Reset: state IDLE. All outputs except ready_o are 0; ready_o = 1.
- ready_o = (state == IDLE), combinational.
- States and transitions:
  - IDLE:
    - Accepts when valid_i=1 and opcode is LOAD or STORE with a legal funct3.
    - Legal load funct3: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU. Legal store funct3: 0 SB, 1 SH, 2 SW.
    - Other opcodes or illegal funct3 are ignored: stay IDLE, no pulse.
    - Misaligned access (H with addr[0]=1, W with addr[1:0]!=0): misaligned_o=1 the next cycle for 1 cycle, no request issued, stay IDLE.
    - Legal aligned access: register addr, be, wdata, we, rd, funct3 and go to REQ.
  - REQ:
    - dmem_req_o=1. addr/be/wdata/we are held stable until dmem_gnt_i.
    - On gnt: a store goes to IDLE; a load goes to WAIT.
    - dmem_req_o drops in the cycle after gnt.
  - WAIT:
    - Memory guarantees rvalid no earlier than the cycle after gnt.
    - On dmem_rvalid_i: capture the extended data; next cycle wb_valid_o=1 for exactly 1 cycle with wb_rd_o and wb_data_o; state goes to IDLE.
    - wb_data_o and wb_rd_o hold their value after the pulse.
- Latency, accept to earliest:
  - Store: gnt-cycle completion at accept+1 when gnt is immediate.
  - Load: wb_valid_o at accept+3 with immediate gnt and rvalid in the next cycle.
- Byte lanes, with o = addr[1:0]:
  - SB: be = 1<<o; wdata = byte replicated x4.
  - SH: be = 0011 (o=0) or 1100 (o=2); wdata = halfword replicated x2.
  - SW: be = 1111; wdata as given.
  - dmem_addr_o = {addr[31:2], 2'b00}.
- Load extract:
  - LB/LBU select byte o; LH/LHU select the half at o[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Boundary cases:
  - valid_i while not ready_o is ignored. EX must hold the op until ready_o=1.
  - dmem_rvalid_i outside WAIT is ignored.
  - gnt outside REQ is ignored.
  - Reset mid-operation: next edge forces IDLE and drops dmem_req_o. No wb_valid_o or misaligned_o pulse for the aborted op.
  - rd_i=0 loads complete normally; WB discards the result.

Decomposition:
- core_lsu_pkg:
  - lsu_state_e enum {IDLE, REQ, WAIT}.
  - OPCODE_LOAD and OPCODE_STORE constants.
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
- One combinational sub-module, lsu_align:
  - Store path: funct3 + offset + wdata -> be + shifted wdata + misaligned flag.
  - Load path: funct3 + offset + rdata -> extended data.
- The FSM and registers live in core_lsu.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, gnt on first REQ cycle -> dmem_addr_o=0x100, be=1111, we=1, wdata=0xDEADBEEF, ready_o back to 1 the cycle after gnt, no wb_valid_o.
- SB addr=0x203, wdata=0x000000A5 -> be=1000, dmem_wdata_o=0xA5A5A5A5, dmem_addr_o=0x200.
- LB addr=0x102, rd=5, rdata=0x12F43456 one cycle after gnt -> wb_valid_o pulse with wb_rd_o=5, wb_data_o=0xFFFFFFF4. The same access with LBU gives 0x000000F4.
- LH addr=0x101 -> misaligned_o pulses 1 cycle, dmem_req_o never asserted, ready_o stays 1.
- Load with gnt delayed 3 cycles -> dmem_req_o, addr and be stable all 4 REQ cycles, ready_o=0 throughout, and valid_i pulses during REQ are ignored.
- rst_i asserted during WAIT, then rvalid arrives -> state IDLE, no wb_valid_o, all outputs at reset values.
